// File: rtl/spi_pkg.sv
// Shared constants for the FIFO-based APB SPI master: register byte offsets,
// register bit positions and the transfer FSM state encoding.
package spi_pkg;

    localparam logic [7:0] REG_CTRL     = 8'h00;
    localparam logic [7:0] REG_DIV      = 8'h04;
    localparam logic [7:0] REG_MODE     = 8'h08;
    localparam logic [7:0] REG_STATUS   = 8'h0C;
    localparam logic [7:0] REG_DATA     = 8'h10;
    localparam logic [7:0] REG_IRQ_EN   = 8'h14;
    localparam logic [7:0] REG_CS_SEL   = 8'h18;
    localparam logic [7:0] REG_IRQ_STAT = 8'h1C;

    localparam int CTRL_EN   = 0;
    localparam int CTRL_LSBF = 1;
    localparam int CTRL_LOOP = 2;

    localparam int MODE_CPHA = 0;
    localparam int MODE_CPOL = 1;

    localparam int ST_BUSY    = 0;
    localparam int ST_TXFULL  = 1;
    localparam int ST_TXEMPTY = 2;
    localparam int ST_RXFULL  = 3;
    localparam int ST_RXEMPTY = 4;

    localparam int IRQ_DONE  = 0;
    localparam int IRQ_TXOVF = 1;
    localparam int IRQ_RXOVF = 2;
    localparam int IRQ_W     = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        SHIFT = 2'd2,
        HOLD  = 2'd3
    } spi_state_e;

endpackage

// File: rtl/spi_fifo.sv
// Synchronous FIFO with show-ahead read data. Push while full and pop while
// empty are ignored; DEPTH must be a power of two.
module spi_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      cnt;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    // Storage needs no reset: emptiness is tracked entirely by the pointers.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    assign rdata = mem[rd_ptr];
    assign full  = (cnt == (AW+1)'(DEPTH));
    assign empty = (cnt == '0);
    assign count = cnt;

endmodule

// File: rtl/spi_master_fifo.sv
// APB SPI master with TX/RX FIFOs, selectable CPOL/CPHA, bit order and CS.
// Optional internal MOSI->MISO loopback (CTRL.LOOP) when SPI_LOOPBACK_EN is defined.
//
// state | meaning
// IDLE  | CS released, SCK parked at CPOL, waiting for EN and TX data
// SETUP | one half-period before the first edge, CS asserted
// SHIFT | 2*DATA_W half-periods of SCK edges
// HOLD  | one half-period after the last edge, then RX push and DONE
module spi_master_fifo
    import spi_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int CS_NUM     = 4,
    parameter int FIFO_DEPTH = 8,
    parameter int DIV_W      = 16
) (
    input  logic              apb_clk,
    input  logic              apb_rst,
    input  logic [7:0]        PADDR,
    input  logic              PSEL,
    input  logic              PENABLE,
    input  logic              PWRITE,
    input  logic [31:0]       PWDATA,
    output logic [31:0]       PRDATA,
    output logic              PREADY,
    output logic              PSLVERR,
    output logic              spi_sck,
    output logic              spi_mosi,
    input  logic              spi_miso,
    output logic [CS_NUM-1:0] spi_cs,
    output logic              irq
);

    localparam int HP_W  = $clog2(2*DATA_W);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [HP_W-1:0] HP_LAST = HP_W'(2*DATA_W - 1);

    logic              acc, wr, rd;
    logic [7:0]        addr;
    logic              ctrl_en, ctrl_lsbf, ctrl_loop;
    logic [DIV_W-1:0]  div_q, div_cnt_q;
    logic              mode_cpha, mode_cpol;
    logic [IRQ_W-1:0]  irq_en_q, irq_stat_q, irq_set, irq_w1c;
    logic [7:0]        cs_sel_q;
    logic              irq_q;

    spi_state_e        state_q, state_d;
    logic              busy, tick;
    logic              load, lead, trail, hold_done, go_idle;
    logic [HP_W-1:0]   hp_q;
    logic              sck_q, mosi_q;
    logic [DATA_W-1:0] tx_sh_q, rx_sh_q;
    logic [CS_NUM-1:0] cs_q, cs_dec;
    logic              miso_int;

    logic              tx_push, tx_pop, tx_full, tx_empty;
    logic              rx_push, rx_pop, rx_full, rx_empty;
    logic              txovf_set, rxovf_set;
    logic [DATA_W-1:0] tx_rdata, rx_rdata;
    logic [CNT_W-1:0]  tx_count, rx_count;
    logic              unused_sig;

    function automatic logic head_bit(input logic [DATA_W-1:0] w, input logic lsbf);
        return lsbf ? w[0] : w[DATA_W-1];
    endfunction

    function automatic logic [DATA_W-1:0] shift_out(input logic [DATA_W-1:0] w, input logic lsbf);
        return lsbf ? (w >> 1) : (w << 1);
    endfunction

    assign acc    = PSEL && PENABLE;
    assign wr     = acc && PWRITE;
    assign rd     = acc && !PWRITE;
    assign addr   = {PADDR[7:2], 2'b00};
    assign PREADY = 1'b1;
    assign busy   = (state_q != IDLE);
    assign tick   = (div_cnt_q == '0);

    assign tx_push   = wr && (addr == REG_DATA) && !tx_full;
    assign txovf_set = wr && (addr == REG_DATA) && tx_full;
    assign rx_pop    = rd && (addr == REG_DATA) && !rx_empty;
    assign rx_push   = hold_done && !rx_full;
    assign rxovf_set = hold_done && rx_full;

    assign unused_sig = ^{PADDR[1:0], PWDATA, tx_count, rx_count};

    spi_fifo #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk   (apb_clk),
        .rst_n (apb_rst),
        .push  (tx_push),
        .wdata (PWDATA[DATA_W-1:0]),
        .pop   (tx_pop),
        .rdata (tx_rdata),
        .full  (tx_full),
        .empty (tx_empty),
        .count (tx_count)
    );

    spi_fifo #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk   (apb_clk),
        .rst_n (apb_rst),
        .push  (rx_push),
        .wdata (rx_sh_q),
        .pop   (rx_pop),
        .rdata (rx_rdata),
        .full  (rx_full),
        .empty (rx_empty),
        .count (rx_count)
    );

    // Timing configuration is frozen while a transfer is in flight.
    always_ff @(posedge apb_clk or negedge apb_rst) begin
        if (!apb_rst) begin
            ctrl_en   <= 1'b0;
            ctrl_lsbf <= 1'b0;
            div_q     <= '0;
            mode_cpha <= 1'b0;
            mode_cpol <= 1'b0;
            irq_en_q  <= '0;
            cs_sel_q  <= '0;
        end else if (wr) begin
            case (addr)
                REG_CTRL: begin
                    ctrl_en   <= PWDATA[CTRL_EN];
                    ctrl_lsbf <= PWDATA[CTRL_LSBF];
                end
                REG_DIV:    if (!busy) div_q <= PWDATA[DIV_W-1:0];
                REG_MODE: begin
                    if (!busy) begin
                        mode_cpha <= PWDATA[MODE_CPHA];
                        mode_cpol <= PWDATA[MODE_CPOL];
                    end
                end
                REG_IRQ_EN: irq_en_q <= PWDATA[IRQ_W-1:0];
                REG_CS_SEL: if (!busy) cs_sel_q <= PWDATA[7:0];
                default: ;
            endcase
        end
    end

`ifdef SPI_LOOPBACK_EN
    always_ff @(posedge apb_clk or negedge apb_rst) begin
        if (!apb_rst)                     ctrl_loop <= 1'b0;
        else if (wr && addr == REG_CTRL)  ctrl_loop <= PWDATA[CTRL_LOOP];
    end
`else
    assign ctrl_loop = 1'b0;
`endif

    assign miso_int = ctrl_loop ? mosi_q : spi_miso;

    always_comb begin
        irq_set            = '0;
        irq_set[IRQ_DONE]  = hold_done;
        irq_set[IRQ_TXOVF] = txovf_set;
        irq_set[IRQ_RXOVF] = rxovf_set;
        irq_w1c            = (wr && addr == REG_IRQ_STAT) ? PWDATA[IRQ_W-1:0] : '0;
    end

    // Hardware set is OR'd in after the clear so it wins a same-cycle W1C.
    always_ff @(posedge apb_clk or negedge apb_rst) begin
        if (!apb_rst) begin
            irq_stat_q <= '0;
            irq_q      <= 1'b0;
        end else begin
            irq_stat_q <= (irq_stat_q & ~irq_w1c) | irq_set;
            irq_q      <= |(irq_stat_q & irq_en_q);
        end
    end

    assign irq = irq_q;

    always_comb begin
        PRDATA = '0;
        if (rd) begin
            case (addr)
                REG_CTRL: begin
                    PRDATA[CTRL_EN]   = ctrl_en;
                    PRDATA[CTRL_LSBF] = ctrl_lsbf;
                    PRDATA[CTRL_LOOP] = ctrl_loop;
                end
                REG_DIV:  PRDATA[DIV_W-1:0] = div_q;
                REG_MODE: begin
                    PRDATA[MODE_CPHA] = mode_cpha;
                    PRDATA[MODE_CPOL] = mode_cpol;
                end
                REG_STATUS: begin
                    PRDATA[ST_BUSY]    = busy;
                    PRDATA[ST_TXFULL]  = tx_full;
                    PRDATA[ST_TXEMPTY] = tx_empty;
                    PRDATA[ST_RXFULL]  = rx_full;
                    PRDATA[ST_RXEMPTY] = rx_empty;
                end
                REG_DATA:     if (!rx_empty) PRDATA[DATA_W-1:0] = rx_rdata;
                REG_IRQ_EN:   PRDATA[IRQ_W-1:0] = irq_en_q;
                REG_CS_SEL:   PRDATA[7:0] = cs_sel_q;
                REG_IRQ_STAT: PRDATA[IRQ_W-1:0] = irq_stat_q;
                default: ;
            endcase
        end
    end

    always_comb begin
        PSLVERR = 1'b0;
        if (wr && busy && (addr == REG_DIV || addr == REG_MODE || addr == REG_CS_SEL))
            PSLVERR = 1'b1;
        if (txovf_set)
            PSLVERR = 1'b1;
        if (rd && addr == REG_DATA && rx_empty)
            PSLVERR = 1'b1;
    end

    always_ff @(posedge apb_clk or negedge apb_rst) begin
        if (!apb_rst) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // Edge k (k = 0 at end of SETUP) is a leading edge when k is even.
    always_comb begin
        state_d   = state_q;
        tx_pop    = 1'b0;
        load      = 1'b0;
        lead      = 1'b0;
        trail     = 1'b0;
        hold_done = 1'b0;
        go_idle   = 1'b0;
        case (state_q)
            IDLE: begin
                if (ctrl_en && !tx_empty) begin
                    tx_pop  = 1'b1;
                    load    = 1'b1;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                if (tick) begin
                    lead    = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (tick) begin
                    if (hp_q == HP_LAST) state_d = HOLD;
                    else if (hp_q[0])    lead    = 1'b1;
                    else                 trail   = 1'b1;
                end
            end
            HOLD: begin
                if (tick) begin
                    hold_done = 1'b1;
                    if (ctrl_en && !tx_empty) begin
                        tx_pop  = 1'b1;
                        load    = 1'b1;
                        state_d = SETUP;
                    end else begin
                        go_idle = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        for (int i = 0; i < CS_NUM; i++) cs_dec[i] = (cs_sel_q != 8'(i));
    end

    always_ff @(posedge apb_clk or negedge apb_rst) begin
        if (!apb_rst) begin
            div_cnt_q <= '0;
            hp_q      <= '0;
            sck_q     <= 1'b0;
            mosi_q    <= 1'b0;
            tx_sh_q   <= '0;
            rx_sh_q   <= '0;
            cs_q      <= '1;
        end else begin
            if (state_q == IDLE || tick) div_cnt_q <= div_q;
            else                         div_cnt_q <= div_cnt_q - DIV_W'(1);

            if (state_q == SETUP)              hp_q <= '0;
            else if (state_q == SHIFT && tick) hp_q <= hp_q + HP_W'(1);

            if (load)               sck_q <= mode_cpol;
            else if (lead || trail) sck_q <= ~sck_q;

            // CPHA=0 presents the first bit at load; CPHA=1 on the leading edge.
            if (load) begin
                if (!mode_cpha) begin
                    mosi_q  <= head_bit(tx_rdata, ctrl_lsbf);
                    tx_sh_q <= shift_out(tx_rdata, ctrl_lsbf);
                end else begin
                    tx_sh_q <= tx_rdata;
                end
            end else if ((lead && mode_cpha) || (trail && !mode_cpha)) begin
                mosi_q  <= head_bit(tx_sh_q, ctrl_lsbf);
                tx_sh_q <= shift_out(tx_sh_q, ctrl_lsbf);
            end

            if ((lead && !mode_cpha) || (trail && mode_cpha)) begin
                if (ctrl_lsbf) rx_sh_q <= {miso_int, rx_sh_q[DATA_W-1:1]};
                else           rx_sh_q <= {rx_sh_q[DATA_W-2:0], miso_int};
            end

            if (load)         cs_q <= cs_dec;
            else if (go_idle) cs_q <= '1;
        end
    end

    assign spi_sck  = (state_q == IDLE) ? mode_cpol : sck_q;
    assign spi_mosi = mosi_q;
    assign spi_cs   = cs_q;

endmodule
